// File: rtl/mem_map_pkg.sv
// Shared types and constants for the Z80 memory-cycle controller.
package mem_map_pkg;

  localparam int unsigned PAGE_W = 4;
  localparam int unsigned WAIT_W = 3;

  localparam logic [PAGE_W-1:0] ROM_PAGE_DEF = 4'hF;
  localparam logic [PAGE_W-1:0] RAM_TOP_DEF  = 4'hE;

  typedef logic [WAIT_W-1:0] wait_t;

  typedef enum logic [1:0] {REG_NONE, REG_ROM, REG_RAM, REG_EXT} region_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  // Wait-state count for a decoded region; unselected cycles never wait.
  function automatic wait_t region_waits(region_t r, wait_t rom_w, wait_t ram_w, wait_t ext_w);
    case (r)
      REG_ROM: region_waits = rom_w;
      REG_RAM: region_waits = ram_w;
      REG_EXT: region_waits = ext_w;
      default: region_waits = '0;
    endcase
  endfunction

endpackage

// File: rtl/mem_cycle_ctrl_if.sv
// Z80 bus strobes in, memory selects / WAIT / boot status out.
interface mem_cycle_ctrl_if;

  localparam int unsigned ADDR_W = 16;

  logic [ADDR_W-1:0] address;
  logic              n_mreq;
  logic              n_iorq;
  logic              n_rd;
  logic              n_wr;
  logic              rom_cs;
  logic              ram_cs;
  logic              ext_cs;
  logic              n_wait;
  logic              boot_active;

  modport master (
    output address, n_mreq, n_iorq, n_rd, n_wr,
    input  rom_cs, ram_cs, ext_cs, n_wait, boot_active
  );

  modport slave (
    input  address, n_mreq, n_iorq, n_rd, n_wr,
    output rom_cs, ram_cs, ext_cs, n_wait, boot_active
  );

endinterface

// File: rtl/wait_state_counter.sv
// Down-counter for wait states; last flags the final wait clock.
module wait_state_counter
  import mem_map_pkg::*;
(
  input  logic  clock,
  input  logic  n_reset,
  input  logic  load,
  input  wait_t load_value,
  input  logic  enable,
  output logic  last,
  output logic  busy
);

  wait_t count;

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - wait_t'(1);
    end
  end

  assign last = (count == wait_t'(1));
  assign busy = (count != '0);

endmodule

// File: rtl/mem_cycle_ctrl.sv
// Memory-cycle controller: region decode, held chip selects, wait states and
// the post-reset boot overlay that maps ROM reads onto page 0.
module mem_cycle_ctrl
  import mem_map_pkg::*;
#(
  parameter logic [PAGE_W-1:0] ROM_PAGE  = ROM_PAGE_DEF,
  parameter logic [PAGE_W-1:0] RAM_TOP   = RAM_TOP_DEF,
  parameter int unsigned       ROM_WAITS = 2,
  parameter int unsigned       RAM_WAITS = 0,
  parameter int unsigned       EXT_WAITS = 3,
  parameter logic [7:0]        BOOT_PORT = 8'h00
) (
  input  logic             clock,
  input  logic             n_reset,
  mem_cycle_ctrl_if.slave  bus
);

  state_t            state, state_n;
  region_t           region_q, region_n, region_dec;
  logic [PAGE_W-1:0] page;
  logic              is_rd;
  logic              cycle_start;
  logic              boot_wr;
  wait_t             start_waits;
  logic              cnt_last, cnt_busy;
  logic              rom_n, ram_n, ext_n, n_wait_n, boot_n;

  assign page        = bus.address[15:12];
  assign is_rd       = !bus.n_rd;
  assign cycle_start = !bus.n_mreq && (!bus.n_rd || !bus.n_wr);
  assign boot_wr     = !bus.n_iorq && !bus.n_wr && (bus.address[7:0] == BOOT_PORT);

  // Region decode; ROM is read-only, so a ROM-page write selects nothing.
  always_comb begin
    region_dec = REG_EXT;
    if (is_rd && ((page == ROM_PAGE) || ((page == '0) && bus.boot_active))) begin
      region_dec = REG_ROM;
    end else if (page < RAM_TOP) begin
      region_dec = REG_RAM;
    end else if (!is_rd && (page == ROM_PAGE)) begin
      region_dec = REG_NONE;
    end
  end

  assign start_waits = region_waits(region_dec, wait_t'(ROM_WAITS),
                                    wait_t'(RAM_WAITS), wait_t'(EXT_WAITS));

  wait_state_counter u_wait_cnt (
    .clock      (clock),
    .n_reset    (n_reset),
    .load       ((state == S_IDLE) && cycle_start),
    .load_value (start_waits),
    .enable     (state == S_WAIT),
    .last       (cnt_last),
    .busy       (cnt_busy)
  );

  always_comb begin
    state_n  = state;
    region_n = region_q;
    case (state)
      S_IDLE: begin
        if (cycle_start) begin
          region_n = region_dec;
          state_n  = (start_waits != '0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        // Releasing MREQ during waits aborts the cycle outright.
        if (bus.n_mreq) begin
          state_n = S_IDLE;
        end else if (cnt_last || !cnt_busy) begin
          state_n = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (bus.n_mreq) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    rom_n    = (state_n != S_IDLE) && (region_n == REG_ROM);
    ram_n    = (state_n != S_IDLE) && (region_n == REG_RAM);
    ext_n    = (state_n != S_IDLE) && (region_n == REG_EXT);
    n_wait_n = (state_n != S_WAIT);
    boot_n   = bus.boot_active && !boot_wr;
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state           <= S_IDLE;
      region_q        <= REG_NONE;
      bus.rom_cs      <= 1'b0;
      bus.ram_cs      <= 1'b0;
      bus.ext_cs      <= 1'b0;
      bus.n_wait      <= 1'b1;
      bus.boot_active <= 1'b1;
    end else begin
      state           <= state_n;
      region_q        <= region_n;
      bus.rom_cs      <= rom_n;
      bus.ram_cs      <= ram_n;
      bus.ext_cs      <= ext_n;
      bus.n_wait      <= n_wait_n;
      bus.boot_active <= boot_n;
    end
  end

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// Scenario bench for mem_cycle_ctrl; expected output vectors are
// {rom_cs, ram_cs, ext_cs, n_wait, boot_active} after each clock edge.
module tb_mem_cycle_ctrl;

  logic clock = 1'b0;
  logic n_reset;

  mem_cycle_ctrl_if bus ();

  mem_cycle_ctrl dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst_n;
    logic [15:0] a;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
  } stim_t;

  logic [4:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic stim_t mk(logic r, logic [15:0] a, logic m, logic io, logic rd, logic wr);
    stim_t s;
    s.rst_n = r; s.a = a; s.mreq_n = m; s.iorq_n = io; s.rd_n = rd; s.wr_n = wr;
    return s;
  endfunction

  function automatic stim_t idle();             return mk(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1); endfunction
  function automatic stim_t mrd(logic [15:0] a);  return mk(1'b1, a, 1'b0, 1'b1, 1'b0, 1'b1); endfunction
  function automatic stim_t mwr(logic [15:0] a);  return mk(1'b1, a, 1'b0, 1'b1, 1'b1, 1'b0); endfunction
  function automatic stim_t iowr(logic [15:0] a); return mk(1'b1, a, 1'b1, 1'b0, 1'b1, 1'b0); endfunction
  function automatic stim_t rfsh(logic [15:0] a); return mk(1'b1, a, 1'b0, 1'b1, 1'b1, 1'b1); endfunction

  // Drive one clock's worth of inputs and record what must follow the edge.
  task automatic drive(input stim_t s, input logic [4:0] e);
    n_reset     = s.rst_n;
    bus.address = s.a;
    bus.n_mreq  = s.mreq_n;
    bus.n_iorq  = s.iorq_n;
    bus.n_rd    = s.rd_n;
    bus.n_wr    = s.wr_n;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    stim_t s [3];
    logic [4:0] e [3];
    logic [4:0] obs, exp_v;
    s = '{mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1),
          mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1), idle()};
    e = '{5'b00011, 5'b00011, 5'b00011};
    for (int i = 0; i < 3; i++) begin
      drive(s[i], e[i]);
      @(posedge clock); #1;
      obs = {bus.rom_cs, bus.ram_cs, bus.ext_cs, bus.n_wait, bus.boot_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset step %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_boot_rom_read();
    stim_t s [5];
    logic [4:0] e [5];
    logic [4:0] obs, exp_v;
    s = '{mrd(16'h0005), mrd(16'h0005), mrd(16'h0005), mrd(16'h0005), idle()};
    e = '{5'b10001, 5'b10001, 5'b10011, 5'b10011, 5'b00011};
    for (int i = 0; i < 5; i++) begin
      drive(s[i], e[i]);
      @(posedge clock); #1;
      obs = {bus.rom_cs, bus.ram_cs, bus.ext_cs, bus.n_wait, bus.boot_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL boot_rom_read step %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_boot_clear();
    stim_t s [6];
    logic [4:0] e [6];
    logic [4:0] obs, exp_v;
    s = '{iowr(16'h5A01), iowr(16'h5A00), idle(), mrd(16'h0005), mrd(16'h0005), idle()};
    e = '{5'b00011, 5'b00010, 5'b00010, 5'b01010, 5'b01010, 5'b00010};
    for (int i = 0; i < 6; i++) begin
      drive(s[i], e[i]);
      @(posedge clock); #1;
      obs = {bus.rom_cs, bus.ram_cs, bus.ext_cs, bus.n_wait, bus.boot_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL boot_clear step %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back_rom();
    stim_t s [7];
    logic [4:0] e [7];
    logic [4:0] obs, exp_v;
    s = '{mwr(16'hF010), mwr(16'hF010), idle(),
          mrd(16'hF010), mrd(16'hF010), mrd(16'hF010), idle()};
    e = '{5'b00010, 5'b00010, 5'b00010, 5'b10000, 5'b10000, 5'b10010, 5'b00010};
    for (int i = 0; i < 7; i++) begin
      drive(s[i], e[i]);
      @(posedge clock); #1;
      obs = {bus.rom_cs, bus.ram_cs, bus.ext_cs, bus.n_wait, bus.boot_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rom_write_read step %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_ext_abort();
    stim_t s [9];
    logic [4:0] e [9];
    logic [4:0] obs, exp_v;
    s = '{mrd(16'hE800), mrd(16'h0005), mrd(16'hE800), mrd(16'hE800), mrd(16'hF000),
          idle(), mrd(16'hE800), idle(), idle()};
    e = '{5'b00100, 5'b00100, 5'b00100, 5'b00110, 5'b00110,
          5'b00010, 5'b00100, 5'b00010, 5'b00010};
    for (int i = 0; i < 9; i++) begin
      drive(s[i], e[i]);
      @(posedge clock); #1;
      obs = {bus.rom_cs, bus.ram_cs, bus.ext_cs, bus.n_wait, bus.boot_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ext_abort step %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_refresh();
    stim_t s [3];
    logic [4:0] e [3];
    logic [4:0] obs, exp_v;
    s = '{rfsh(16'h1234), rfsh(16'hE800), idle()};
    e = '{5'b00010, 5'b00010, 5'b00010};
    for (int i = 0; i < 3; i++) begin
      drive(s[i], e[i]);
      @(posedge clock); #1;
      obs = {bus.rom_cs, bus.ram_cs, bus.ext_cs, bus.n_wait, bus.boot_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL refresh step %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_midcycle();
    stim_t s [9];
    logic [4:0] e [9];
    logic [4:0] obs, exp_v;
    stim_t rst_rd;
    rst_rd = mrd(16'hF010);
    rst_rd.rst_n = 1'b0;
    s = '{mrd(16'hF010), rst_rd, idle(), mwr(16'h0005), idle(),
          mrd(16'h0005), mrd(16'h0005), mrd(16'h0005), idle()};
    e = '{5'b10000, 5'b00011, 5'b00011, 5'b01011, 5'b00011,
          5'b10001, 5'b10001, 5'b10011, 5'b00011};
    for (int i = 0; i < 9; i++) begin
      drive(s[i], e[i]);
      @(posedge clock); #1;
      obs = {bus.rom_cs, bus.ram_cs, bus.ext_cs, bus.n_wait, bus.boot_active};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_midcycle step %0d: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot_rom_read();
    test_boot_clear();
    test_back_to_back_rom();
    test_ext_abort();
    test_refresh();
    test_reset_midcycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
